// File: rtl/fir_pkg.sv
// fir_pkg: shared types and constants for the FIR MAC sequencer.
//   fir_state_t  - sequencer state encoding (StIdle..StDone)
//   Fir*         - default widths: taps, sample/coef width, fraction bits, accumulator width
//   round_full   - round-half-up arithmetic shift of the accumulator by FirFrac
//   sat_hit      - 1 when the rounded value falls outside the DW-bit signed range
//   round_shift  - rounded and narrowed output sample (clamped when FIR_OUT_SAT_EN is defined,
//                  two's-complement wrap otherwise)
package fir_pkg;

  localparam int unsigned FirTaps = 32;
  localparam int unsigned FirDw   = 16;
  localparam int unsigned FirFrac = 15;
  localparam int unsigned FirAw   = $clog2(FirTaps);
  localparam int unsigned FirAccW = 2 * FirDw + FirAw;

  localparam logic signed [FirAccW-1:0] FirRoundBias = {{(FirAccW-1){1'b0}}, 1'b1} << (FirFrac - 1);
  localparam logic signed [FirAccW-1:0] FirYMax = {{(FirAccW-FirDw+1){1'b0}}, {(FirDw-1){1'b1}}};
  localparam logic signed [FirAccW-1:0] FirYMin = {{(FirAccW-FirDw+1){1'b1}}, {(FirDw-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StShift = 3'd2,
    StMac   = 3'd3,
    StDrain = 3'd4,
    StOut   = 3'd5,
    StDone  = 3'd6
  } fir_state_t;

  function automatic logic signed [FirAccW-1:0] round_full(input logic signed [FirAccW-1:0] acc);
    logic signed [FirAccW-1:0] biased;
    biased = acc + FirRoundBias;
    return biased >>> FirFrac;
  endfunction

  function automatic logic sat_hit(input logic signed [FirAccW-1:0] acc);
    logic signed [FirAccW-1:0] y_full;
    y_full = round_full(acc);
    return (y_full > FirYMax) || (y_full < FirYMin);
  endfunction

  function automatic logic [FirDw-1:0] round_shift(input logic signed [FirAccW-1:0] acc);
`ifdef FIR_OUT_SAT_EN
    // A clamp can only go low when the accumulator itself is negative.
    if (sat_hit(acc)) begin
      return acc[FirAccW-1] ? {1'b1, {(FirDw-1){1'b0}}} : {1'b0, {(FirDw-1){1'b1}}};
    end
`endif
    return FirDw'(round_full(acc));
  endfunction

endpackage

// File: rtl/fir_mac_acc.sv
// fir_mac_acc: signed DW x DW multiplier feeding an AccW-bit signed accumulator.
//   clk, rst_n - clock, synchronous active-low reset (accumulator to 0)
//   clr        - clear accumulator (has priority over en)
//   en         - add a*b into the accumulator this cycle
//   a, b       - signed multiplicands
//   acc        - accumulator value
module fir_mac_acc #(
  parameter int unsigned DW   = 16,
  parameter int unsigned AccW = 37
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [AccW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AccW-1:0] acc_q, acc_d;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(AccW-2*DW){prod[2*DW-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: FIR datapath sequencer. Per output it strobes the sample shift register, walks
// tap/coef addresses 0..TAPS-1, multiply-accumulates, rounds, and hands one sample out over
// valid/ready. Emits n_samples + TAPS - 1 outputs (full convolution).
//   clk, rst_n           - clock, synchronous active-low reset
//   start, n_samples     - run request and input sample count (taken in idle only)
//   busy, done           - run in progress / one-cycle end-of-run pulse
//   shift_clr, shift_new - shift register clear and shift strobes
//   tap_addr, tap_data   - shift register read port (data one cycle after address)
//   coef_addr, coef_data - coefficient read port (data one cycle after address)
//   y_data, y_valid, y_ready - output handshake
//   sat_flag             - sticky clamp indicator, present only with FIR_OUT_SAT_EN defined
// Build option: FIR_OUT_SAT_EN clamps outputs to the DW-bit signed range instead of wrapping.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int unsigned TAPS = FirTaps,
  parameter int unsigned FRAC = FirFrac,
  parameter int unsigned DW   = FirDw
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [13:0]             n_samples,
  output logic                    busy,
  output logic                    done,
  output logic                    shift_clr,
  output logic                    shift_new,
  output logic [$clog2(TAPS)-1:0] tap_addr,
  input  logic signed [DW-1:0]    tap_data,
  output logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic signed [DW-1:0]    coef_data,
  output logic signed [DW-1:0]    y_data,
  output logic                    y_valid,
`ifdef FIR_OUT_SAT_EN
  output logic                    sat_flag,
`endif
  input  logic                    y_ready
);

  localparam int unsigned AW   = $clog2(TAPS);
  localparam int unsigned AccW = 2 * DW + AW;

  localparam logic [14:0]   NOutBias = 15'(TAPS - 1);
  localparam logic [AW-1:0] KLast    = AW'(TAPS - 1);

  localparam logic signed [AccW-1:0] RoundBias = {{(AccW-1){1'b0}}, 1'b1} << (FRAC - 1);

  fir_state_t state_q, state_d;

  logic [14:0]   n_out_q, n_out_d;
  logic [14:0]   cnt_q, cnt_d;
  logic [14:0]   cnt_inc;
  logic [AW-1:0] k_q, k_d;
  logic          mac_vld_q;

  logic                   acc_clr;
  logic                   acc_en;
  logic signed [AccW-1:0] acc;
  logic signed [AccW-1:0] acc_rnd;
  logic signed [AccW-1:0] y_full;
  logic [DW-1:0]          y_nar;

  assign cnt_inc = cnt_q + 15'd1;

  // Next-state logic. n_samples == 0 is recognised as n_out == TAPS - 1.
  always_comb begin
    state_d = state_q;
    n_out_d = n_out_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_out_d = {1'b0, n_samples} + NOutBias;
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = '0;
        state_d = (n_out_q == NOutBias) ? StDone : StShift;
      end
      StShift: begin
        k_d     = '0;
        state_d = StMac;
      end
      StMac: begin
        k_d = k_q + AW'(1);
        if (k_q == KLast) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StOut;
      end
      StOut: begin
        if (y_ready) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == n_out_q) ? StDone : StShift;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      n_out_q   <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      mac_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_out_q   <= n_out_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      // Read data lags the address by one cycle; this flag marks a product as real.
      mac_vld_q <= (state_q == StMac);
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign shift_clr = (state_q == StClear);
  assign shift_new = (state_q == StShift);
  assign y_valid   = (state_q == StOut);
  assign tap_addr  = (state_q == StMac) ? k_q : '0;
  assign coef_addr = tap_addr;

  assign acc_clr = (state_q == StShift);
  assign acc_en  = mac_vld_q;

  fir_mac_acc #(
    .DW   (DW),
    .AccW (AccW)
  ) u_mac_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .a     (tap_data),
    .b     (coef_data),
    .acc   (acc)
  );

  // Round half up, then arithmetic shift down to the output scale.
  assign acc_rnd = acc + RoundBias;
  assign y_full  = acc_rnd >>> FRAC;

`ifdef FIR_OUT_SAT_EN
  localparam logic signed [AccW-1:0] YMax = {{(AccW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AccW-1:0] YMin = {{(AccW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic sat_hi;
  logic sat_lo;
  logic sat_q;

  assign sat_hi = (y_full > YMax);
  assign sat_lo = (y_full < YMin);

  always_comb begin
    y_nar = DW'(y_full);
    if (sat_hi) begin
      y_nar = {1'b0, {(DW-1){1'b1}}};
    end else if (sat_lo) begin
      y_nar = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (state_q == StClear) begin
      sat_q <= 1'b0;
    end else if ((state_q == StOut) && (sat_hi || sat_lo)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign y_nar = DW'(y_full);
`endif

  // The accumulator is frozen for the whole of StOut, so y_data derived from it stays stable
  // while the handshake is stalled.
  assign y_data = (state_q == StOut) ? y_nar : '0;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq: scoreboard bench for fir_mac_seq with a behavioural shift register and
// coefficient ROM. Honours FIR_OUT_SAT_EN the same way as the design.
`timescale 1ns/1ps
module tb_fir_mac_seq;
  import fir_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] n_samples;
  logic        busy, done, shift_clr, shift_new;
  logic [4:0]  tap_addr, coef_addr;
  logic signed [15:0] tap_data, coef_data;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_ready;
`ifdef FIR_OUT_SAT_EN
  logic        sat_flag;
`endif

  always #5 clk = ~clk;

  fir_mac_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_samples (n_samples),
    .busy      (busy),
    .done      (done),
    .shift_clr (shift_clr),
    .shift_new (shift_new),
    .tap_addr  (tap_addr),
    .tap_data  (tap_data),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y_data    (y_data),
    .y_valid   (y_valid),
`ifdef FIR_OUT_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .y_ready   (y_ready)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Environment: sample shift register with zero-fill and a coefficient ROM.
  logic signed [15:0] xs    [64];
  logic signed [15:0] coefs [32];
  logic signed [15:0] sr    [32];
  int n_cur = 0;
  int sidx  = 0;

  always @(posedge clk) begin
    if (shift_clr) begin
      for (int k = 0; k < 32; k++) sr[k] <= '0;
      sidx <= 0;
    end else if (shift_new) begin
      sr[0] <= (sidx < n_cur) ? xs[sidx] : 16'sd0;
      for (int k = 1; k < 32; k++) sr[k] <= sr[k-1];
      sidx <= sidx + 1;
    end
    tap_data  <= sr[tap_addr];
    coef_data <= coefs[coef_addr];
  end

  // Scoreboard and event monitor.
  logic [15:0] exp_q [$];
  logic [15:0] got_y [128];
  longint cyc = 0;
  int hs_cnt, valid_cnt, snew_cnt, sclr_cnt, done_cnt;
  longint done_cyc, last_hs_cyc, first_valid_cyc, start_cyc;
  bit exp_sat;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (shift_new) snew_cnt++;
      if (shift_clr) sclr_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (y_valid) begin
        if (valid_cnt == 0) first_valid_cyc = cyc;
        valid_cnt++;
      end
      if (y_valid && y_ready) begin
        check_eq("y_q_empty", exp_q.size() == 0, 0);
        if (exp_q.size() != 0) check_eq($sformatf("y[%0d]", hs_cnt), y_data, exp_q.pop_front());
        if (hs_cnt < 128) got_y[hs_cnt] = y_data;
        hs_cnt++;
        last_hs_cyc = cyc;
      end
    end
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_sclr"}, shift_clr, 0);
    check_eq({tag, "_snew"}, shift_new, 0);
    check_eq({tag, "_taddr"}, tap_addr, 0);
    check_eq({tag, "_caddr"}, coef_addr, 0);
    check_eq({tag, "_ydata"}, y_data, 0);
    check_eq({tag, "_yvalid"}, y_valid, 0);
`ifdef FIR_OUT_SAT_EN
    check_eq({tag, "_sat"}, sat_flag, 0);
`endif
  endtask

  task automatic prep(input int n);
    logic signed [36:0] a37;
    exp_q.delete();
    hs_cnt = 0; valid_cnt = 0; snew_cnt = 0; sclr_cnt = 0; done_cnt = 0;
    done_cyc = 0; last_hs_cyc = 0; first_valid_cyc = 0;
    exp_sat = 0;
    n_cur = n;
    if (n > 0) begin
      for (int o = 0; o < n + 31; o++) begin
        longint s;
        s = 0;
        for (int k = 0; k < 32; k++) begin
          if (o - k >= 0 && o - k < n) s += longint'(xs[o-k]) * longint'(coefs[k]);
        end
        a37 = s[36:0];
        exp_q.push_back(round_shift(a37));
`ifdef FIR_OUT_SAT_EN
        if (sat_hit(a37)) exp_sat = 1;
`endif
      end
    end
  endtask

  task automatic kick(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    n_samples = 14'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_case(input string name, input int n, input bit bp, input bit poke);
    int n_out, budget, guard, bp_st, hold_n, hold_snew;
    logic [15:0] hold_y;
    n_out = (n == 0) ? 0 : n + 31;
    budget = (n + 32) * 40 + 100;
    prep(n);
    kick(n);
    guard = 0; bp_st = 0; hold_n = 0; hold_snew = 0; hold_y = '0;
    while (done_cnt == 0 && guard < budget) begin
      @(posedge clk); #1;
      guard++;
      if (poke && guard == 40) begin
        start = 1'b1;
        n_samples = 14'd5;
      end else begin
        start = 1'b0;
      end
      if (bp) begin
        case (bp_st)
          0: if (hs_cnt == 3) begin y_ready = 1'b0; bp_st = 1; end
          1: if (y_valid) begin hold_y = y_data; hold_snew = snew_cnt; bp_st = 2; end
          2: begin
            check_eq({name, "_bp_valid"}, y_valid, 1);
            check_eq({name, "_bp_data"}, y_data, hold_y);
            check_eq({name, "_bp_snew"}, snew_cnt, hold_snew);
            hold_n++;
            if (hold_n == 10) begin y_ready = 1'b1; bp_st = 3; end
          end
          default: ;
        endcase
      end
    end
    start = 1'b0;
    y_ready = 1'b1;
    check_eq({name, "_busy_end"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq({name, "_done_cnt"}, done_cnt, 1);
    check_eq({name, "_outs"}, hs_cnt, n_out);
    check_eq({name, "_q_left"}, exp_q.size(), 0);
    check_eq({name, "_sclr_cnt"}, sclr_cnt, 1);
    check_eq({name, "_snew_cnt"}, snew_cnt, n_out);
    if (n == 0) begin
      check_eq({name, "_done_lat"}, done_cyc - start_cyc, 2);
      check_eq({name, "_valid_cnt"}, valid_cnt, 0);
    end else begin
      check_eq({name, "_first_lat"}, first_valid_cyc - start_cyc, 36);
      check_eq({name, "_done_after"}, done_cyc - last_hs_cyc, 1);
    end
`ifdef FIR_OUT_SAT_EN
    check_eq({name, "_sat"}, sat_flag, exp_sat);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; n_samples = '0; y_ready = 1'b1;
    for (int i = 0; i < 64; i++) xs[i] = '0;
    for (int k = 0; k < 32; k++) begin coefs[k] = '0; sr[k] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // Impulse through flat coefficients.
    xs[0] = 16'sh4000;
    for (int k = 0; k < 32; k++) coefs[k] = 16'sh4000;
    run_case("imp", 1, 0, 0);
    check_eq("imp_y0", got_y[0], 16'h2000);
    check_eq("imp_y31", got_y[31], 16'h2000);

    // Coefficient ordering and rounding.
    xs[0] = 16'sh7FFF;
    for (int k = 0; k < 32; k++) coefs[k] = 16'(k * 256);
    run_case("ord", 1, 0, 0);
    check_eq("ord_y5", got_y[5], 16'h0500);
    check_eq("ord_y31", got_y[31], 16'h1F00);

    // Backpressure on output 3, plus a start pulse while busy.
    xs[0] = 16'sh4000;
    for (int k = 0; k < 32; k++) coefs[k] = 16'sh4000;
    run_case("bp", 1, 1, 1);

    // Full-scale window: clamps or wraps depending on the build.
    for (int i = 0; i < 32; i++) xs[i] = 16'sh7FFF;
    for (int k = 0; k < 32; k++) coefs[k] = 16'sh7FFF;
    run_case("sat", 32, 0, 0);
`ifdef FIR_OUT_SAT_EN
    check_eq("sat_y31", got_y[31], 16'h7FFF);
`else
    check_eq("sat_y31", got_y[31], 16'hFFC0);
`endif

    // Empty run.
    run_case("zero", 0, 0, 0);

    // Random mixed-sign data.
    for (int i = 0; i < 20; i++) xs[i] = 16'($urandom);
    for (int k = 0; k < 32; k++) coefs[k] = 16'($urandom);
    run_case("rnd", 20, 0, 0);

    // Reset in the middle of output 7's MAC phase.
    for (int i = 0; i < 10; i++) xs[i] = 16'(i * 1000 - 3000);
    for (int k = 0; k < 32; k++) coefs[k] = 16'(k * 512 - 4096);
    prep(10);
    kick(10);
    guard = 0;
    while (!(hs_cnt == 7 && tap_addr == 5) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("mid_reached", (hs_cnt == 7) && (tap_addr == 5), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("midrst");
    rst_n = 1'b1;
    exp_q.delete();

    // Fresh run after the reset.
    xs[0] = 16'sh4000;
    for (int i = 1; i < 64; i++) xs[i] = '0;
    for (int k = 0; k < 32; k++) coefs[k] = 16'sh4000;
    run_case("post", 1, 0, 0);
    check_eq("post_y7", got_y[7], 16'h2000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
